fpu_seq_ctrl: RTL and testbench
===============================

# fpu_seq_ctrl

Sequencer and scoreboard for the shared multi-cycle floating-point unit in the execute stage. It accepts one FP operation at a time from EX and runs it for a fixed per-op latency. It holds the result until the writeback port grants a slot. It also raises a stall, which the hazard logic ORs into StallF/StallD/StallE, whenever a younger instruction needs the busy unit or reads its pending destination.

## Interface
Parameters:
- LAT_ADD, 3: cycles in RUN for ADD/SUB (1..31)
- LAT_MUL, 4: cycles in RUN for MUL (1..31)
- LAT_DIV, 16: cycles in RUN for DIV (1..31)
- LAT_SQRT, 20: cycles in RUN for SQRT (1..31)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- issue_valid  in  1  FP op in EX requests the unit
- issue_op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 SQRT, others illegal
- issue_rd  in  5  FP destination register of issuing op
- flush  in  1  pipeline flush (taken branch in EX)
- fp_src_D  in  1  decode-stage instruction reads FP registers
- rs1_D, rs2_D  in  5 each  FP source registers of decode instruction
- wb_grant  in  1  FP writeback port free this cycle
- fpu_start  out  1  one-cycle start pulse to FPU datapath
- fpu_op  out  3  latched op code driven to FPU
- result_valid  out  1  result ready, awaiting writeback
- wb_rd  out  5  destination of held result
- busy  out  1  state != IDLE
- StallFP  out  1  stall request to hazard logic
- illegal_op  out  1  one-cycle pulse: issued op rejected

## Operation
- States: IDLE, RUN, DONE. Reset (rst=0 at a clock edge): state IDLE, cnt 0, pend_rd 0, pending 0, all outputs 0. Reset applied mid-RUN/DONE discards the operation.
- accept = issue_valid & !flush & legal(issue_op) & (IDLE | (DONE & wb_grant)).
- On accept: state←RUN, fpu_op←issue_op, pend_rd←issue_rd, pending←1, cnt←LAT(op)−1, fpu_start←1 next cycle only.
- RUN: if cnt==0 then state←DONE, else cnt←cnt−1. Counter width is 5 bits; no wrap, because the load value is ≤30.
- DONE: result_valid=1, wb_rd=pend_rd. On wb_grant: state←IDLE and pending←0, unless a new accept occurs in the same cycle. In that case go directly to RUN.
- A flush with issue_valid in the same cycle suppresses the accept. A flush never cancels an op already in RUN/DONE, since that op is older than the branch.
- An illegal op with issue_valid & !flush does not change state. It gives illegal_op=1 in the next cycle.
- StallFP (combinational) = structural | data.
  - structural = issue_valid & !flush & !(IDLE | (DONE & wb_grant)).
  - data = fp_src_D & pending & (rs1_D==pend_rd | rs2_D==pend_rd).
- f0 is a real FP register. There is no register-0 exclusion.

## Timing
- Accept at edge T. fpu_start=1 during cycle T+1. RUN occupies T+1..T+LAT. result_valid rises at T+LAT+1.
- result_valid stays high until the cycle in which wb_grant=1; it falls the following cycle.
- Back-to-back ops: a DONE+wb_grant cycle accepts the next op with zero bubbles. The new fpu_start follows one cycle later.
- StallFP is asserted in the same cycle as the condition. Data stall clears the cycle after the writeback grant clears pending.
- fpu_op and wb_rd are stable from accept until the next accept.

## Configuration
- FPU_SQRT_EN defined: op 100 is legal and uses LAT_SQRT.
- FPU_SQRT_EN undefined: op 100 is illegal. It yields an illegal_op pulse, no state change, and no stall. LAT_SQRT is unused.

## Test plan
- ADD, rd=5, issued at T with wb_grant=1: fpu_start at T+1, RUN T+1..T+3, result_valid/wb_rd=5 at T+4, IDLE at T+5.
- DIV rd=7, then decode instruction with rs2_D=7 and fp_src_D=1: StallFP=1 until pending clears. Same stimulus with fp_src_D=0: StallFP=0.
- DIV in RUN plus new MUL issue_valid: StallFP=1 each cycle. With wb_grant=1 at DONE, the MUL is accepted that cycle and fpu_start pulses the next cycle.
- Hold wb_grant=0 for 5 cycles after DONE: result_valid and wb_rd held steady. Grant on cycle 6: IDLE next cycle.
- issue_valid with flush=1: no fpu_start and busy stays 0. rst=0 mid-RUN of SQRT: all outputs 0 the next cycle.
- op 100 with FPU_SQRT_EN: result at T+21. Without FPU_SQRT_EN: illegal_op pulse at T+1 and busy=0. op 111 gives illegal_op in both builds.

Source files
------------

// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: sequencer/scoreboard for the shared multi-cycle FPU (IDLE/RUN/DONE) with stall generation.
// Optional square root is enabled by defining FPU_SQRT_EN.
module fpu_seq_ctrl #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [2:0] issue_op,
  input  logic [4:0] issue_rd,
  input  logic       flush,
  input  logic       fp_src_D,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic       wb_grant,
  output logic       fpu_start,
  output logic [2:0] fpu_op,
  output logic       result_valid,
  output logic [4:0] wb_rd,
  output logic       busy,
  output logic       StallFP,
  output logic       illegal_op
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0] r_state;
  logic [4:0] r_cnt, r_pend_rd;
  logic [2:0] r_op;
  logic       r_start, r_illegal;
  logic       w_legal, w_issue, w_avail, w_accept, w_pending;
  logic [4:0] w_load;
`ifdef FPU_SQRT_EN
  assign w_legal = issue_op <= 3'd4;
`else
  assign w_legal = issue_op <= 3'd3;
`endif
  always_comb begin
    w_load = issue_op == 3'd2 ? 5'(LAT_MUL - 1) :
             issue_op == 3'd3 ? 5'(LAT_DIV - 1) :
             issue_op == 3'd4 ? 5'(LAT_SQRT - 1) : 5'(LAT_ADD - 1);
  end
  assign w_issue   = issue_valid & ~flush;
  // Unit can take a new op when idle, or when the held result leaves this cycle.
  assign w_avail   = (r_state == S_IDLE) | ((r_state == S_DONE) & wb_grant);
  assign w_accept  = w_issue & w_legal & w_avail;
  assign w_pending = r_state != S_IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_pend_rd <= 5'd0;
      r_op      <= 3'd0;
      r_start   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_start   <= w_accept;
      r_illegal <= w_issue & ~w_legal;
      if (w_accept) begin
        r_state   <= S_RUN;
        r_op      <= issue_op;
        r_pend_rd <= issue_rd;
        r_cnt     <= w_load;
      end else if (r_state == S_RUN) begin
        if (r_cnt == 5'd0) r_state <= S_DONE;
        else r_cnt <= r_cnt - 5'd1;
      end else if (r_state == S_DONE && wb_grant) begin
        r_state <= S_IDLE;
      end
    end
  end
  assign fpu_start    = r_start;
  assign fpu_op       = r_op;
  assign result_valid = r_state == S_DONE;
  assign wb_rd        = r_pend_rd;
  assign busy         = w_pending;
  assign illegal_op   = r_illegal;
  assign StallFP      = (w_issue & ~w_avail) |
                        (fp_src_D & w_pending & (rs1_D == r_pend_rd | rs2_D == r_pend_rd));
endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb_fpu_seq_ctrl: directed plus randomized bench for fpu_seq_ctrl against a timestamp-based reference model.
module tb_fpu_seq_ctrl;
  logic clk = 0, rst = 0, issue_valid = 0, flush = 0, fp_src_D = 0, wb_grant = 0;
  logic [2:0] issue_op = 0;
  logic [4:0] issue_rd = 0, rs1_D = 0, rs2_D = 0;
  logic fpu_start, result_valid, busy, StallFP, illegal_op;
  logic [2:0] fpu_op;
  logic [4:0] wb_rd;
  int errors = 0, checks = 0;
`ifdef FPU_SQRT_EN
  localparam bit SQRT_EN = 1'b1;
`else
  localparam bit SQRT_EN = 1'b0;
`endif

  fpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
    .flush(flush), .fp_src_D(fp_src_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .wb_grant(wb_grant),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .result_valid(result_valid), .wb_rd(wb_rd),
    .busy(busy), .StallFP(StallFP), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Reference model: an op in flight is described by its destination and the edge index at which its result appears.
  bit m_act = 0, m_start = 0, m_ill = 0, chk_en = 0;
  int m_now = 0, m_ready = 0;
  logic [4:0] m_rd = 0;
  logic [2:0] m_op = 0;

  function automatic int lat(input logic [2:0] op);
    return op == 3'd2 ? 4 : op == 3'd3 ? 16 : op == 3'd4 ? 20 : 3;
  endfunction

  function automatic bit legal(input logic [2:0] op);
    return op <= 3'd3 || (SQRT_EN && op == 3'd4);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit done, acc;
    done = m_act && m_now >= m_ready;
    m_now++;
    if (!rst) begin
      m_act = 0; m_rd = 0; m_op = 0; m_start = 0; m_ill = 0;
    end else begin
      acc = issue_valid && !flush && legal(issue_op) && (!m_act || (done && wb_grant));
      m_start = acc;
      m_ill = issue_valid && !flush && !legal(issue_op);
      if (acc) begin
        m_act = 1; m_op = issue_op; m_rd = issue_rd; m_ready = m_now + lat(issue_op);
      end else if (done && wb_grant) m_act = 0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    bit done, stall;
    done = m_act && m_now >= m_ready;
    stall = (issue_valid && !flush && !(!m_act || (done && wb_grant))) ||
            (fp_src_D && m_act && (rs1_D == m_rd || rs2_D == m_rd));
    check("busy", 32'(busy), 32'(m_act));
    check("result_valid", 32'(result_valid), 32'(done));
    check("wb_rd", 32'(wb_rd), 32'(m_rd));
    check("fpu_op", 32'(fpu_op), 32'(m_op));
    check("fpu_start", 32'(fpu_start), 32'(m_start));
    check("illegal_op", 32'(illegal_op), 32'(m_ill));
    check("StallFP", 32'(StallFP), 32'(stall));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rd);
    issue_valid = 1; issue_op = op; issue_rd = rd;
    tick();
    issue_valid = 0;
  endtask

  initial begin
    tick(); tick();
    chk_en = 1;
    check("rst_busy", 32'(busy), 0);
    check("rst_rv", 32'(result_valid), 0);
    check("rst_wb_rd", 32'(wb_rd), 0);
    check("rst_start", 32'(fpu_start), 0);
    check("rst_stall", 32'(StallFP), 0);
    rst = 1; wb_grant = 1;
    tick();
    // ADD rd=5 with grant held high
    issue(3'd0, 5'd5);
    check("add_start", 32'(fpu_start), 1);
    check("add_busy", 32'(busy), 1);
    tick();
    check("add_start_once", 32'(fpu_start), 0);
    check("add_rv_early", 32'(result_valid), 0);
    tick(); tick();
    check("add_rv", 32'(result_valid), 1);
    check("add_wb_rd", 32'(wb_rd), 5);
    tick();
    check("add_idle", 32'(busy), 0);
    // DIV rd=7: data hazard then structural hazard
    wb_grant = 0;
    issue(3'd3, 5'd7);
    fp_src_D = 1; rs2_D = 7; #1;
    check("data_stall", 32'(StallFP), 1);
    fp_src_D = 0; #1;
    check("no_src_no_stall", 32'(StallFP), 0);
    issue_valid = 1; issue_op = 3'd2; issue_rd = 5'd9; #1;
    check("struct_stall", 32'(StallFP), 1);
    repeat (16) tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_rv", 32'(result_valid), 1);
      check("hold_wb_rd", 32'(wb_rd), 7);
      tick();
    end
    wb_grant = 1; #1;
    check("grant_no_stall", 32'(StallFP), 0);
    tick();
    issue_valid = 0;
    check("b2b_start", 32'(fpu_start), 1);
    check("b2b_op", 32'(fpu_op), 2);
    check("b2b_wb_rd", 32'(wb_rd), 9);
    repeat (5) tick();
    check("mul_idle", 32'(busy), 0);
    // flush suppresses accept
    issue_valid = 1; flush = 1; issue_op = 3'd0;
    tick();
    issue_valid = 0; flush = 0;
    check("flush_start", 32'(fpu_start), 0);
    check("flush_busy", 32'(busy), 0);
    issue(3'd7, 5'd1);
    check("ill7", 32'(illegal_op), 1);
    check("ill7_busy", 32'(busy), 0);
    tick();
    check("ill7_pulse", 32'(illegal_op), 0);
    issue(3'd4, 5'd3);
    if (SQRT_EN) begin
      check("sqrt_busy", 32'(busy), 1);
      repeat (19) tick();
      check("sqrt_rv_early", 32'(result_valid), 0);
      tick();
      check("sqrt_rv", 32'(result_valid), 1);
      tick();
    end else begin
      check("sqrt_ill", 32'(illegal_op), 1);
      check("sqrt_busy", 32'(busy), 0);
    end
    // reset in the middle of a running op
    issue(3'd3, 5'd2);
    tick(); tick();
    rst = 0;
    tick();
    check("mrst_busy", 32'(busy), 0);
    check("mrst_wb_rd", 32'(wb_rd), 0);
    check("mrst_op", 32'(fpu_op), 0);
    rst = 1;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(63) != 0;
      issue_valid = $urandom_range(1);
      flush = $urandom_range(9) == 0;
      issue_op = $urandom_range(4) == 0 ? 3'($urandom_range(7)) : 3'($urandom_range(3));
      issue_rd = 5'($urandom_range(3));
      fp_src_D = $urandom_range(1);
      rs1_D = 5'($urandom_range(3));
      rs2_D = 5'($urandom_range(3));
      wb_grant = $urandom_range(9) < 6;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
